// File: rtl/ldpc_syndrome_judge_if.sv
// Request/result bundle between iteration control and the syndrome judge.
// The master starts checks and holds vout/shift_tab; the slave (judge) reports the verdict.
interface ldpc_syndrome_judge_if #(
   parameter int Z     = 64,
   parameter int MB    = 16,
   parameter int NB    = 32,
   parameter int SW    = 7,
   parameter int CNT_W = 16,
   parameter int FR_W  = 10
);
   logic                  start;
   logic                  abort;
   logic                  mode_all;
   logic [NB*Z-1:0]       vout;
   logic [MB*NB*SW-1:0]   shift_tab;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [CNT_W-1:0]      fail_cnt;
   logic [FR_W-1:0]       first_fail_row;

   modport master (
      output start, abort, mode_all, vout, shift_tab,
      input  busy, done, pass, fail_cnt, first_fail_row
   );

   modport slave (
      input  start, abort, mode_all, vout, shift_tab,
      output busy, done, pass, fail_cnt, first_fail_row
   );
endinterface

// File: rtl/ldpc_syndrome_judge.sv
// QC-LDPC syndrome check with early termination: RPC block-rows per cycle,
// reporting pass/fail, unsatisfied-check count and the first failing check row.

// One block-row: Z parity checks over all NB column blocks.
module ldpc_syndrome_judge_row #(
   parameter int Z  = 64,
   parameter int NB = 32,
   parameter int SW = 7
) (
   input  logic [NB*Z-1:0]  vout,
   input  logic [NB*SW-1:0] shifts,
   output logic [Z-1:0]     chk
);
   always_comb begin
      logic [SW-1:0] s;
      int            idx;
      chk = '0;
      s   = '0;
      idx = 0;
      for (int j = 0; j < NB; j++) begin
         s = shifts[j*SW +: SW];
         // any shift >= Z (including all-ones) is a null circulant
         if (int'(s) < Z) begin
            for (int r = 0; r < Z; r++) begin
               idx = r + int'(s);
               if (idx >= Z) idx = idx - Z;
               chk[r] = chk[r] ^ vout[j*Z + idx];
            end
         end
      end
   end
endmodule

module ldpc_syndrome_judge #(
   parameter int Z     = 64,
   parameter int MB    = 16,
   parameter int NB    = 32,
   parameter int SW    = 7,
   parameter int RPC   = 4,
   parameter int CNT_W = 16,
   parameter int FR_W  = 10
) (
   input logic                   clk,
   input logic                   rst_n,
   ldpc_syndrome_judge_if.slave  bus
);
   localparam int G    = MB / RPC;
   localparam int GW   = (G > 1) ? $clog2(G) : 1;
   localparam int NCHK = RPC * Z;
   localparam int LW   = (NCHK > 1) ? $clog2(NCHK) : 1;
   localparam int PW   = $clog2(NCHK + 1);
   localparam int SUMW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

   state_t                      state, state_nx;
   logic [GW-1:0]               grp;
   logic                        mode_q;
   logic [CNT_W-1:0]            acc;
   logic                        found;
   logic [FR_W-1:0]             ff_q;

   logic [RPC-1:0][NB*SW-1:0]   row_sh;
   logic [RPC-1:0][Z-1:0]       row_chk;
   logic [NCHK-1:0]             chk;
   logic [PW-1:0]               pc;
   logic [LW-1:0]               lo;
   logic                        any;
   logic [SUMW-1:0]             sum;
   logic [CNT_W-1:0]            acc_nx;
   logic [FR_W-1:0]             ff_nx;
   logic                        last, fin, go;

   generate
      for (genvar q = 0; q < RPC; q++) begin : g_row
         assign row_sh[q] = bus.shift_tab[(int'(grp)*RPC + q)*NB*SW +: NB*SW];
         ldpc_syndrome_judge_row #(.Z(Z), .NB(NB), .SW(SW)) u_row (
            .vout   (bus.vout),
            .shifts (row_sh[q]),
            .chk    (row_chk[q])
         );
      end
   endgenerate

   assign chk = row_chk;

   // popcount and lowest failing index within the current group
   always_comb begin
      pc  = '0;
      lo  = '0;
      any = 1'b0;
      for (int n = NCHK - 1; n >= 0; n--) begin
         pc = pc + PW'(chk[n]);
         if (chk[n]) begin
            lo  = LW'(n);
            any = 1'b1;
         end
      end
   end

   assign sum    = SUMW'(acc) + SUMW'(pc);
   assign acc_nx = (sum > SUMW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
   assign ff_nx  = found ? ff_q : (any ? FR_W'(int'(grp)*NCHK + int'(lo)) : '0);
   assign last   = (grp == GW'(G - 1));
   assign fin    = (!mode_q && any) || last;
   assign go     = bus.start && !bus.abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (go) state_nx = CHECK;
         CHECK:   if (bus.abort) state_nx = IDLE;
                  else if (fin)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == CHECK);
      bus.done = (state == DONE);
   end

   // result registers load on the CHECK->DONE edge so they are valid with done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grp                <= '0;
         mode_q             <= 1'b0;
         acc                <= '0;
         found              <= 1'b0;
         ff_q               <= '0;
         bus.pass           <= 1'b0;
         bus.fail_cnt       <= '0;
         bus.first_fail_row <= '0;
      end else begin
         case (state)
            IDLE: if (go) begin
               mode_q <= bus.mode_all;
               grp    <= '0;
               acc    <= '0;
               found  <= 1'b0;
               ff_q   <= '0;
            end
            CHECK: if (!bus.abort) begin
               acc   <= acc_nx;
               found <= found | any;
               ff_q  <= ff_nx;
               if (fin) begin
                  bus.pass           <= (acc_nx == '0);
                  bus.fail_cnt       <= acc_nx;
                  bus.first_fail_row <= (acc_nx == '0) ? '0 : ff_nx;
               end else begin
                  grp <= grp + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
